// File: rtl/ulbf_coeffs_pkg.sv
// Shared definitions for the ULBF coefficient streaming controller.
// Holds the controller FSM state encoding and the default values of the
// parameters used by ulbf_coeffs_stream_ctrl and ulbf_coeffs_sync_fifo.
package ulbf_coeffs_pkg;

    localparam int unsigned DefaultDataWidth      = 64;
    localparam int unsigned DefaultRamReadLatency = 4;
    localparam int unsigned DefaultAddrWidth      = 16;
    localparam int unsigned DefaultFifoDepth      = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/ulbf_coeffs_sync_fifo.sv
// Single-clock first-word-fall-through FIFO used as the stream output buffer.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   push/wdata write side; a push while full is dropped
//   pop/rdata  read side; rdata shows the head entry, zero while empty
//   empty      no entries stored
//   count      current occupancy, 0..DEPTH
module ulbf_coeffs_sync_fifo
    import ulbf_coeffs_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultDataWidth + 1,
    parameter int unsigned DEPTH = DefaultFifoDepth,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;

    // Gate the head with empty so the outputs read zero out of reset without
    // having to reset the storage array.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/ulbf_coeffs_stream_ctrl.sv
// Streams num_blocks repetitions of a block of block_len RAM words, starting at
// base_addr, out of a fixed-latency RAM read port onto an AXI-Stream master.
// Ports:
//   m_axis_clk, m_axis_rst        clock, asynchronous active-high reset
//   start, base_addr, block_len,  transfer request; operands sampled when the
//   num_blocks                    start is accepted in IDLE
//   enb, addrb, doutb             RAM port B (doutb valid RAM_READ_LATENCY
//                                 cycles after enb)
//   m_axis_tdata/tvalid/tready/   output stream; tlast marks the final word of
//   tlast                         every block
//   busy, done                    busy from accepted start until done; done is a
//                                 one-cycle pulse after the final beat
module ulbf_coeffs_stream_ctrl
    import ulbf_coeffs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = DefaultDataWidth,
    parameter int unsigned RAM_READ_LATENCY = DefaultRamReadLatency,
    parameter int unsigned ADDR_WIDTH       = DefaultAddrWidth,
    parameter int unsigned FIFO_DEPTH       = DefaultFifoDepth
) (
    input  logic                  m_axis_clk,
    input  logic                  m_axis_rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] block_len,
    input  logic [7:0]            num_blocks,
    output logic                  enb,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] doutb,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW:0] DepthVal = (CntW + 1)'(FIFO_DEPTH);

    state_e state_q;
    state_e state_d;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] word_q;
    logic [7:0]            nblk_q;
    logic [7:0]            blk_q;

    logic [RAM_READ_LATENCY-1:0] pipe_vld_q;
    logic [RAM_READ_LATENCY-1:0] pipe_last_q;

    logic [CntW-1:0]   fifo_count;
    logic [CntW-1:0]   in_flight;
    logic [CntW:0]     outstanding;
    logic              fifo_empty;
    logic [DATA_WIDTH:0] fifo_rdata;

    logic start_empty;
    logic start_run;
    logic room;
    logic last_in_block;
    logic last_read;
    logic pop;
    logic drain_done;

    assign start_empty   = (block_len == '0) || (num_blocks == '0);
    assign start_run     = (state_q == StIdle) && start && !start_empty;
    assign last_in_block = (word_q == len_q - ADDR_WIDTH'(1));
    assign last_read     = last_in_block && (blk_q == nblk_q - 8'd1);
    assign pop           = m_axis_tvalid && m_axis_tready;

    always_comb begin
        in_flight = '0;
        for (int unsigned i = 0; i < RAM_READ_LATENCY; i++) begin
            in_flight = in_flight + CntW'(pipe_vld_q[i]);
        end
    end

    // Reads are only issued while every word already owed to the FIFO still
    // fits, so the buffer can never overflow whatever tready does.
    assign outstanding = {1'b0, fifo_count} + {1'b0, in_flight};
    assign room        = (outstanding < DepthVal);

    // Nothing left in flight and the FIFO is empty or loses its last word now.
    assign drain_done = (in_flight == '0) &&
                        ((fifo_count == '0) || ((fifo_count == CntW'(1)) && pop));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge m_axis_clk or posedge m_axis_rst) begin
        if (m_axis_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = start_empty ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (enb && last_read) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (drain_done) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        enb  = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StIssue: begin
                enb  = room;
                busy = 1'b1;
            end
            StDrain: busy = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------- read sequencer
    // addr_q always holds the address presented on addrb; after the final read
    // it is left alone so addrb keeps the last issued address.
    always_ff @(posedge m_axis_clk or posedge m_axis_rst) begin
        if (m_axis_rst) begin
            base_q <= '0;
            len_q  <= '0;
            nblk_q <= '0;
            addr_q <= '0;
            word_q <= '0;
            blk_q  <= '0;
        end else if (start_run) begin
            base_q <= base_addr;
            len_q  <= block_len;
            nblk_q <= num_blocks;
            addr_q <= base_addr;
            word_q <= '0;
            blk_q  <= '0;
        end else if (enb) begin
            if (last_in_block) begin
                word_q <= '0;
                blk_q  <= blk_q + 8'd1;
                if (!last_read) begin
                    addr_q <= base_q;
                end
            end else begin
                word_q <= word_q + ADDR_WIDTH'(1);
                addr_q <= addr_q + ADDR_WIDTH'(1);
            end
        end
    end

    assign addrb = addr_q;

    // Valid/last tags ride alongside the RAM read latency; the last stage
    // lines up with doutb for the read issued RAM_READ_LATENCY cycles earlier.
    always_ff @(posedge m_axis_clk or posedge m_axis_rst) begin
        if (m_axis_rst) begin
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            pipe_vld_q[0]  <= enb;
            pipe_last_q[0] <= enb && last_in_block;
            for (int unsigned i = 1; i < RAM_READ_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end
        end
    end

    // ---------------------------------------------------------- output FIFO
    ulbf_coeffs_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (m_axis_clk),
        .rst   (m_axis_rst),
        .push  (pipe_vld_q[RAM_READ_LATENCY-1]),
        .wdata ({pipe_last_q[RAM_READ_LATENCY-1], doutb}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tlast  = fifo_rdata[DATA_WIDTH];
    assign m_axis_tdata  = fifo_rdata[DATA_WIDTH-1:0];

endmodule
